// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pong_game_ctrl
// Purpose  : Frame-tick driven Pong sequencer owning ball/paddle motion,
//            wall and paddle collisions, scoring and game-state control.
// Revision : 1.0  initial release
// ============================================================================
module pong_game_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int PADDLE_W     = 10,
  parameter int PADDLE_H     = 50,
  parameter int P2_X         = 630,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_SPEED = 3,
  parameter int BALL_XV      = 3,
  parameter int BALL_YV      = 1,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] p1_y,
  output logic [9:0] p2_y,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [2:0] state,
  output logic [1:0] winner
);

  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SERVE     = 3'd1;
  localparam logic [2:0] S_PLAY      = 3'd2;
  localparam logic [2:0] S_SCORE     = 3'd3;
  localparam logic [2:0] S_GAME_OVER = 3'd4;

  localparam logic [10:0] BALL_X0    = 11'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [10:0] BALL_Y0    = 11'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [10:0] PAD_Y0     = 11'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [10:0] PAD_MAX    = 11'(SCREEN_H - PADDLE_H);
  localparam logic [10:0] BALL_Y_MAX = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] K_PW       = 11'(PADDLE_W);
  localparam logic [10:0] K_PH       = 11'(PADDLE_H);
  localparam logic [10:0] K_BS       = 11'(BALL_SIZE);
  localparam logic [10:0] K_P2X      = 11'(P2_X);
  localparam logic [10:0] K_SW       = 11'(SCREEN_W);
  localparam logic [10:0] K_XV       = 11'(BALL_XV);
  localparam logic [10:0] K_YV       = 11'(BALL_YV);
  localparam logic [10:0] K_PS       = 11'(PADDLE_SPEED);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

  logic [2:0]       state_q, state_d;
  logic [10:0]      ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [10:0]      p1_y_q, p1_y_d, p2_y_q, p2_y_d;
  logic             dx_q, dx_d, dy_q, dy_d;  // 1 = moving right / down
  logic [3:0]       p1_score_q, p1_score_d, p2_score_q, p2_score_d;
  logic [1:0]       winner_q, winner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ov1, ov2, p1_bounce, p2_bounce, p1_point, p2_point, serve_done, game_won;

  function automatic logic [10:0] paddle_step(input logic [10:0] y, input logic up,
                                              input logic dn);
    paddle_step = y;
    if (up && !dn)      paddle_step = (y < K_PS) ? 11'd0 : y - K_PS;
    else if (dn && !up) paddle_step = (y + K_PS > PAD_MAX) ? PAD_MAX : y + K_PS;
  endfunction

  assign ov1 = (ball_y_q + K_BS > p1_y_q) && (ball_y_q < p1_y_q + K_PH);
  assign ov2 = (ball_y_q + K_BS > p2_y_q) && (ball_y_q < p2_y_q + K_PH);
  assign p1_bounce = !dx_q && (ball_x_q >= K_PW) && (ball_x_q <= K_PW + K_XV) && ov1;
  assign p2_point  = !dx_q && !p1_bounce && (ball_x_q <= K_XV);
  assign p2_bounce = dx_q && (ball_x_q + K_BS <= K_P2X) &&
                     (ball_x_q + K_BS + K_XV >= K_P2X) && ov2;
  assign p1_point  = dx_q && !p2_bounce && (ball_x_q + K_BS + K_XV >= K_SW);
  assign serve_done = (cnt_q == CNT_LAST);
  assign game_won   = (p1_score_q == WIN) || (p2_score_q == WIN);

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ball_x_q   <= BALL_X0;
      ball_y_q   <= BALL_Y0;
      p1_y_q     <= PAD_Y0;
      p2_y_q     <= PAD_Y0;
      dx_q       <= 1'b1;
      dy_q       <= 1'b1;
      p1_score_q <= 4'd0;
      p2_score_q <= 4'd0;
      winner_q   <= 2'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
      p1_y_q     <= p1_y_d;
      p2_y_q     <= p2_y_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      p1_score_q <= p1_score_d;
      p2_score_q <= p2_score_d;
      winner_q   <= winner_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_SERVE;
      S_SERVE:     if (frame_tick && serve_done) state_d = S_PLAY;
      S_PLAY:      if (frame_tick && (p1_point || p2_point)) state_d = S_SCORE;
      S_SCORE:     if (frame_tick) state_d = game_won ? S_GAME_OVER : S_SERVE;
      S_GAME_OVER: if (start) state_d = S_SERVE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath: every branch reads only pre-tick register values.
  always_comb begin
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
    p1_y_d     = p1_y_q;
    p2_y_d     = p2_y_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    winner_d   = winner_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_SERVE: if (frame_tick) begin
        p1_y_d = paddle_step(p1_y_q, p1_up, p1_down);
        p2_y_d = paddle_step(p2_y_q, p2_up, p2_down);
        cnt_d  = serve_done ? '0 : cnt_q + CNT_W'(1);
      end
      S_PLAY: if (frame_tick) begin
        p1_y_d = paddle_step(p1_y_q, p1_up, p1_down);
        p2_y_d = paddle_step(p2_y_q, p2_up, p2_down);
        if (!dy_q && (ball_y_q < K_YV)) begin
          ball_y_d = 11'd0;
          dy_d     = 1'b1;
        end else if (dy_q && (ball_y_q + K_YV > BALL_Y_MAX)) begin
          ball_y_d = BALL_Y_MAX;
          dy_d     = 1'b0;
        end else begin
          ball_y_d = dy_q ? ball_y_q + K_YV : ball_y_q - K_YV;
        end
        // A point leaves the ball where it is; the serve re-centres it.
        if (p1_bounce) begin
          ball_x_d = K_PW;
          dx_d     = 1'b1;
        end else if (p2_bounce) begin
          ball_x_d = K_P2X - K_BS;
          dx_d     = 1'b0;
        end else if (p2_point) begin
          p2_score_d = (p2_score_q < WIN) ? p2_score_q + 4'd1 : p2_score_q;
          dx_d       = 1'b0;
        end else if (p1_point) begin
          p1_score_d = (p1_score_q < WIN) ? p1_score_q + 4'd1 : p1_score_q;
          dx_d       = 1'b1;
        end else begin
          ball_x_d = dx_q ? ball_x_q + K_XV : ball_x_q - K_XV;
        end
      end
      S_SCORE: if (frame_tick) begin
        if (game_won) begin
          winner_d = (p1_score_q == WIN) ? 2'd1 : 2'd2;
        end else begin
          ball_x_d = BALL_X0;
          ball_y_d = BALL_Y0;
        end
      end
      S_GAME_OVER: if (start) begin
        p1_score_d = 4'd0;
        p2_score_d = 4'd0;
        winner_d   = 2'd0;
        ball_x_d   = BALL_X0;
        ball_y_d   = BALL_Y0;
      end
      default: ;
    endcase
  end

  always_comb begin
    ball_x   = ball_x_q[9:0];
    ball_y   = ball_y_q[9:0];
    p1_y     = p1_y_q[9:0];
    p2_y     = p2_y_q[9:0];
    p1_score = p1_score_q;
    p2_score = p2_score_q;
    state    = state_q;
    winner   = winner_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_game_ctrl
// Purpose  : Self-checking bench for pong_game_ctrl against a game-rule model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pong_game_ctrl;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b0, frame_tick = 1'b0, start = 1'b0;
  logic       p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic [9:0] ball_x, ball_y, p1_y, p2_y;
  logic [3:0] p1_score, p2_score;
  logic [2:0] state;
  logic [1:0] winner;
  logic [52:0] dut_vec;

  int checks = 0;
  int errors = 0;

  // Reference game state, in plain integers with signed velocities.
  int m_state, m_x, m_y, m_p1, m_p2, m_s1, m_s2, m_win, m_cnt, m_dx, m_dy;

  pong_game_ctrl dut (
    .clk_50(clk_50), .reset(reset), .frame_tick(frame_tick), .start(start),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .ball_x(ball_x), .ball_y(ball_y), .p1_y(p1_y), .p2_y(p2_y),
    .p1_score(p1_score), .p2_score(p2_score), .state(state), .winner(winner)
  );

  always #10 clk_50 = ~clk_50;

  assign dut_vec = {ball_x, ball_y, p1_y, p2_y, p1_score, p2_score, state, winner};

  function automatic logic [52:0] model_vec();
    return {10'(m_x), 10'(m_y), 10'(m_p1), 10'(m_p2), 4'(m_s1), 4'(m_s2),
            3'(m_state), 2'(m_win)};
  endfunction

  function automatic int pad_move(input int y, input bit up, input bit dn);
    if (up && !dn) return (y - 3 < 0) ? 0 : y - 3;
    if (dn && !up) return (y + 3 > 430) ? 430 : y + 3;
    return y;
  endfunction

  task automatic model_step(input bit rst, input bit tk, input bit st, input bit u1,
                            input bit d1, input bit u2, input bit d2);
    int ox, oy, o1, o2;
    if (rst) begin
      m_state = 0; m_x = 316; m_y = 236; m_p1 = 215; m_p2 = 215;
      m_s1 = 0; m_s2 = 0; m_win = 0; m_cnt = 0; m_dx = 1; m_dy = 1;
      return;
    end
    case (m_state)
      0: if (st) m_state = 1;
      1: if (tk) begin
        m_p1 = pad_move(m_p1, u1, d1);
        m_p2 = pad_move(m_p2, u2, d2);
        if (m_cnt == 59) begin m_cnt = 0; m_state = 2; end
        else m_cnt++;
      end
      2: if (tk) begin
        ox = m_x; oy = m_y; o1 = m_p1; o2 = m_p2;
        m_p1 = pad_move(o1, u1, d1);
        m_p2 = pad_move(o2, u2, d2);
        if (m_dy < 0 && oy < 1) begin m_y = 0; m_dy = 1; end
        else if (m_dy > 0 && oy + 1 > 472) begin m_y = 472; m_dy = -1; end
        else m_y = oy + m_dy;
        if (m_dx < 0) begin
          if (ox >= 10 && ox <= 13 && oy + 8 > o1 && oy < o1 + 50) begin
            m_x = 10; m_dx = 1;
          end else if (ox <= 3) begin
            if (m_s2 < 7) m_s2++;
            m_dx = -1; m_state = 3;
          end else m_x = ox - 3;
        end else begin
          if (ox + 8 <= 630 && ox + 11 >= 630 && oy + 8 > o2 && oy < o2 + 50) begin
            m_x = 622; m_dx = -1;
          end else if (ox + 11 >= 640) begin
            if (m_s1 < 7) m_s1++;
            m_dx = 1; m_state = 3;
          end else m_x = ox + 3;
        end
      end
      3: if (tk) begin
        if (m_s1 == 7 || m_s2 == 7) begin
          m_state = 4; m_win = (m_s1 == 7) ? 1 : 2;
        end else begin
          m_state = 1; m_x = 316; m_y = 236;
        end
      end
      4: if (st) begin
        m_s1 = 0; m_s2 = 0; m_win = 0; m_x = 316; m_y = 236; m_state = 1;
      end
      default: ;
    endcase
  endtask

  task automatic drive(input bit rst, input bit tk, input bit st, input bit u1,
                       input bit d1, input bit u2, input bit d2);
    reset = rst; frame_tick = tk; start = st;
    p1_up = u1; p1_down = d1; p2_up = u2; p2_down = d2;
    model_step(rst, tk, st, u1, d1, u2, d2);
    @(posedge clk_50);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 0, 0, 1);
    checks++; if (ball_x !== 10'd316) begin errors++; $display("FAIL reset_ball_x: got %0d want 316", ball_x); end
    checks++; if (ball_y !== 10'd236) begin errors++; $display("FAIL reset_ball_y: got %0d want 236", ball_y); end
    checks++; if (p1_y !== 10'd215) begin errors++; $display("FAIL reset_p1_y: got %0d want 215", p1_y); end
    checks++; if (p2_y !== 10'd215) begin errors++; $display("FAIL reset_p2_y: got %0d want 215", p2_y); end
    checks++; if (p1_score !== 4'd0 || p2_score !== 4'd0) begin errors++; $display("FAIL reset_scores: got %0d/%0d want 0/0", p1_score, p2_score); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (winner !== 2'd0) begin errors++; $display("FAIL reset_winner: got %0d want 0", winner); end
  endtask

  task automatic test_serve();
    drive(0, 0, 1, 0, 0, 0, 0);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL serve_enter: state got %0d want 1", state); end
    for (int i = 0; i < 60; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      if (i == 58) begin
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL serve_hold: state got %0d want 1", state); end
      end
    end
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL serve_to_play: state got %0d want 2", state); end
    checks++; if (ball_x !== 10'd316 || ball_y !== 10'd236) begin errors++; $display("FAIL serve_centre: got %0d,%0d want 316,236", ball_x, ball_y); end
    drive(0, 1, 0, 0, 0, 0, 0);
    checks++; if (ball_x !== 10'd319 || ball_y !== 10'd237) begin errors++; $display("FAIL first_play_step: got %0d,%0d want 319,237", ball_x, ball_y); end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (dut_vec !== model_vec()) begin errors++; $display("FAIL no_tick_hold: got %h want %h", dut_vec, model_vec()); end
  endtask

  task automatic test_paddles();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 72; i++) begin
      drive(0, 1, 0, 1, 0, 0, 1);
      if (i == 70) begin
        checks++; if (p1_y !== 10'd2) begin errors++; $display("FAIL p1_up_71: got %0d want 2", p1_y); end
      end
    end
    checks++; if (p1_y !== 10'd0 || p2_y !== 10'd430) begin errors++; $display("FAIL paddle_sat_72: got %0d,%0d want 0,430", p1_y, p2_y); end
    for (int i = 0; i < 28; i++) drive(0, 1, 0, 1, 0, 0, 1);
    checks++; if (p1_y !== 10'd0 || p2_y !== 10'd430) begin errors++; $display("FAIL paddle_sat_100: got %0d,%0d want 0,430", p1_y, p2_y); end
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, 1, 0, 0);
    checks++; if (p1_y !== 10'd30) begin errors++; $display("FAIL p1_down: got %0d want 30", p1_y); end
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 1, 1, 1, 1);
    checks++; if (p1_y !== 10'd30 || p2_y !== 10'd430) begin errors++; $display("FAIL both_buttons: got %0d,%0d want 30,430", p1_y, p2_y); end
    checks++; if (dut_vec !== model_vec()) begin errors++; $display("FAIL paddle_model: got %h want %h", dut_vec, model_vec()); end
  endtask

  task automatic test_random_game();
    bit done, tk, st, u1, d1, u2, d2;
    done = 0;
    for (int i = 0; i < 60000 && !done && errors < 50; i++) begin
      tk = ($urandom_range(0, 1) == 0);
      st = ($urandom_range(0, 7) == 0);
      u1 = 1'($urandom_range(0, 1)); d1 = 1'($urandom_range(0, 1));
      u2 = 1'($urandom_range(0, 1)); d2 = 1'($urandom_range(0, 1));
      // Occasionally steer towards the ball so paddle hits and rallies occur.
      if (i < 30000 && $urandom_range(0, 3) == 0) begin
        u1 = (m_p1 + 25 > m_y + 4); d1 = !u1;
      end
      if (i < 30000 && $urandom_range(0, 3) == 0) begin
        u2 = (m_p2 + 25 > m_y + 4); d2 = !u2;
      end
      drive(0, tk, st, u1, d1, u2, d2);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL random_step %0d: got %h want %h", i, dut_vec, model_vec());
      end
      if (m_state == 4) done = 1;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL game_over_timeout: state got %0d want 4", state); end
  endtask

  task automatic test_game_over();
    logic [52:0] frozen;
    int exp_win;
    exp_win = (m_s1 == 7) ? 1 : 2;
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL game_over_state: got %0d want 4", state); end
    checks++; if (winner !== 2'(exp_win)) begin errors++; $display("FAIL game_over_winner: got %0d want %0d", winner, exp_win); end
    frozen = model_vec();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++; if (dut_vec !== frozen) begin errors++; $display("FAIL game_over_frozen: got %h want %h", dut_vec, frozen); end
    end
    drive(0, 0, 1, 0, 0, 0, 0);
    checks++; if (p1_score !== 4'd0 || p2_score !== 4'd0 || winner !== 2'd0) begin errors++; $display("FAIL restart_clear: got %0d/%0d/%0d want 0/0/0", p1_score, p2_score, winner); end
    checks++; if (state !== 3'd1 || ball_x !== 10'd316 || ball_y !== 10'd236) begin errors++; $display("FAIL restart_serve: got st=%0d %0d,%0d want st=1 316,236", state, ball_x, ball_y); end
  endtask

  task automatic test_reset_mid_play();
    for (int i = 0; i < 65; i++) drive(0, 1, 0, 0, 1, 1, 0);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL mid_play_state: got %0d want 2", state); end
    drive(1, 1, 1, 0, 1, 1, 0);
    checks++; if (dut_vec !== {10'd316, 10'd236, 10'd215, 10'd215, 4'd0, 4'd0, 3'd0, 2'd0}) begin
      errors++; $display("FAIL reset_mid_play: got %h want %h", dut_vec, {10'd316, 10'd236, 10'd215, 10'd215, 4'd0, 4'd0, 3'd0, 2'd0});
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    checks++; if (state !== 3'd0 || dut_vec !== model_vec()) begin errors++; $display("FAIL idle_after_reset: got %h want %h", dut_vec, model_vec()); end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_paddles();
    test_random_game();
    test_game_over();
    test_reset_mid_play();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
